// File: rtl/result_reader.sv
// -----------------------------------------------------------------------------
// result_reader
//
// Streams a contiguous region of result words out of a pair of SRAM macros.
// Each SRAM word holds two results side by side, {upper, lower}; for every
// word the block issues one read on port 1 of both macros, captures the
// returned word one cycle later, and hands the lower result then the upper
// result to a valid/ready consumer.  The address counter walks from the start
// address to the end address inclusive, wrapping through 2^ADDR_W-1 to 0 when
// the start lies above the end.
//
// Parameters
//   ADDR_W         SRAM word address width
//   DATA_W         width of one result
//   MEM_WORD_SIZE  combined width of both SRAM halves (2*DATA_W)
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         asynchronous active-high reset
//   start_i       one-cycle request to stream a region (honoured only in IDLE)
//   start_addr_i  first word address, sampled with an accepted start
//   end_addr_i    last word address (inclusive), sampled with an accepted start
//   csb_o         active-low read chip select shared by both macros
//   addr_o        read address shared by both macros (always the counter)
//   rdata_i       read data {upper macro dout1, lower macro dout1}
//   res_valid_o   result valid
//   res_ready_i   downstream ready
//   res_data_o    result value
//   res_last_o    final result of the region
//   busy_o        high whenever the FSM is not in IDLE
//   done_o        one-cycle completion pulse
// -----------------------------------------------------------------------------
module result_reader #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    output logic                     csb_o,
    output logic [ADDR_W-1:0]        addr_o,
    input  logic [MEM_WORD_SIZE-1:0] rdata_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [DATA_W-1:0]        res_data_o,
    output logic                     res_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        SEND_LO = 3'd3,
        SEND_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                   state;
    logic [ADDR_W-1:0]        counter;
    logic [ADDR_W-1:0]        end_addr;
    logic [MEM_WORD_SIZE-1:0] hold;

    // The read address is the counter itself, so it is stable in every state
    // and simply stays at the end address once the region has finished.
    assign addr_o = counter;

    // Single FSM process.  Every output is a register that is loaded together
    // with the state it belongs to, so the outputs change exactly on the edge
    // that enters the corresponding state and are glitch-free toward the SRAM
    // and the consumer.  res_data_o is loaded on entry to SEND_LO (straight
    // from rdata_i, the same value that lands in hold) and on entry to SEND_HI,
    // which keeps it stable for as long as the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            counter     <= '0;
            end_addr    <= '0;
            hold        <= '0;
            csb_o       <= 1'b1;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        counter  <= start_addr_i;
                        end_addr <= end_addr_i;
                        csb_o    <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= READ;
                    end
                end

                READ: begin
                    csb_o <= 1'b1;
                    state <= WAIT;
                end

                // The macros return data one cycle after csb_o was sampled
                // low, so rdata_i is valid during this state.
                WAIT: begin
                    hold        <= rdata_i;
                    res_data_o  <= rdata_i[DATA_W-1:0];
                    res_valid_o <= 1'b1;
                    state       <= SEND_LO;
                end

                SEND_LO: begin
                    if (res_ready_i) begin
                        res_data_o <= hold[MEM_WORD_SIZE-1:DATA_W];
                        res_last_o <= (counter == end_addr);
                        state      <= SEND_HI;
                    end
                end

                // Comparing before incrementing means a wrapping region
                // (start above end) simply runs through the top address and
                // the counter's natural overflow back to zero.
                SEND_HI: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        res_last_o  <= 1'b0;
                        if (counter == end_addr) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            counter <= counter + ADDR_ONE;
                            csb_o   <= 1'b0;
                            state   <= READ;
                        end
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    csb_o       <= 1'b1;
                    res_valid_o <= 1'b0;
                    res_last_o  <= 1'b0;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
